ife_multicore_dispatcher: RTL and testbench
===========================================

Name: ife_multicore_dispatcher

Overview:
- Parametrised successor of the two-core IFE dispatch path.
- Queues incoming instruction blocks and dispatches each one to any of NUM_CORES cores using round-robin selection.
- Enforces serial-block barriers and reports block completion in dispatch order.
- Sits between the external block source and the array of nebula cores; replaces the fixed serial/parallel muxing at SoC top.

Parameters:
- NUM_CORES, 4, number of cores served (>=2; need not be a power of two).
- BLOCK_WORDS, 4, 32-bit instruction words per block.
- ID_W, 8, block identifier width.
- FIFO_DEPTH, 8, input block queue depth (>=2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  block offered.
- in_ready  out  1  queue can accept.
- in_id  in  ID_W  block id.
- in_data  in  BLOCK_WORDS*32  block words; word 0 in LSBs.
- in_serial  in  1  block must run with no other block in flight.
- core_busy  in  NUM_CORES  per-core busy from cores.
- core_done  in  NUM_CORES  per-core one-cycle completion pulse.
- disp_valid  out  NUM_CORES  one-hot dispatch pulse.
- disp_id  out  ID_W  id of dispatched block (shared bus).
- disp_data  out  BLOCK_WORDS*32  dispatched block (shared bus).
- commit_valid  out  1  one-cycle commit pulse.
- commit_id  out  ID_W  committed block id.
- commit_core  out  $clog2(NUM_CORES)  core that ran the committed block.
- inflight_cnt  out  $clog2(NUM_CORES+1)  blocks dispatched but not yet committed.
- err_spurious  out  1  sticky: core_done seen on a core with no block in flight.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Clears FIFO, inflight flags, order queue, rr_ptr=0 and err_spurious.
  - Outputs during/after reset: in_ready=0 while rst_n=0, then 1; disp_valid=0; disp_id=0; disp_data=0; commit_valid=0; commit_id=0; commit_core=0; inflight_cnt=0.
  - Reset mid-operation drops all queued and in-flight blocks; no commits are issued for them.
- Enqueue:
  - A block is accepted when in_valid && in_ready.
  - in_ready = !fifo_full. It does not look ahead to a same-cycle dequeue.
- Free core i: !core_busy[i] && !inflight[i].
- Dispatch, at most one per cycle, evaluated on the FIFO head:
  - Parallel head (serial=0): grant the first free core searching from rr_ptr upward with wrap. Then rr_ptr <= grant+1 mod NUM_CORES.
  - Serial head: dispatch only when inflight_cnt==0 and core 0 is free; always to core 0; rr_ptr unchanged.
  - A parallel block behind a queued serial block waits (FIFO is strictly in-order).
  - If no core is eligible, the head stalls.
- Dispatch outputs are registered:
  - On the grant edge, disp_valid[g] goes high for exactly one cycle, disp_id/disp_data carry the head, inflight[g] is set, the FIFO pops, and g is pushed into the order queue.
  - disp_id/disp_data hold their last value when disp_valid=0.
  - Minimum latency: block accepted at edge N -> disp_valid at the cycle after edge N+1 (one cycle in FIFO).
- Commit ordering (order queue depth NUM_CORES holds core index + id):
  - core_done[i] with inflight[i] sets done[i].
  - core_done[i] with !inflight[i] sets err_spurious and is otherwise ignored.
  - When done[head] is set: commit_valid pulses for one cycle with the head id/core; inflight and done for that core are cleared; the queue pops.
  - At most one commit per cycle. Earliest commit is the cycle after core_done.
  - An out-of-order completion is held until all older blocks commit.
- Simultaneous events:
  - Dispatch and commit in the same cycle are both performed; inflight_cnt stays unchanged.
  - A freed core is eligible for dispatch on the cycle after its commit, not the same cycle.
  - core_done in the same cycle as that core's dispatch is treated as spurious.
- inflight_cnt = number of set inflight flags; it never exceeds NUM_CORES.

Decomposition:
- Package ife_pkg:
  - block_t struct {id, serial, data}.
  - Constants BLOCK_BITS = BLOCK_WORDS*32 and CORE_IDX_W = $clog2(NUM_CORES).
  - Round-robin search function rr_pick(free_mask, ptr).
- One sub-module: ife_block_fifo, a parametrised synchronous FIFO of block_t with full/empty flags and the same clk/rst_n.
- The order queue is a small inline circular buffer inside the top module.

Test Plan:
- Reset, then 4 parallel blocks ids 1..4 with all cores idle -> disp_valid 0001, 0010, 0100, 1000 on consecutive cycles, each with the matching id; rr_ptr wraps to 0.
- core_busy=0010, 2 parallel blocks starting from rr_ptr=1 -> grants go to cores 2 and 3; core 1 is skipped.
- Dispatch ids 5,6,7 to cores 0,1,2; core_done on 2, then 0, then 1 -> commit order 5 (core 0), 6 (core 1), 7 (core 2), with no commit before core 1 completes.
- Parallel id 8 in flight, serial id 9 queued, parallel id 10 queued -> id 9 waits until 8 commits, then dispatches to core 0; id 10 dispatches only after 9 commits.
- Fill 8 blocks with all cores busy -> in_ready=0 after the 8th accept; releasing core 0 -> one dispatch, and in_ready=1 the following cycle.
- core_done[3] with nothing in flight -> err_spurious=1 and sticky; assert rst_n=0 mid-stream with 3 blocks queued -> all outputs return to reset values and no further disp_valid or commit_valid occurs.

Source files
------------

// File: rtl/ife_pkg.sv
// Shared configuration, block record and round-robin helpers for the multicore IFE dispatcher.
// All block/core widths derive from the constants below; resize the dispatcher here.
package ife_pkg;

    localparam int NUM_CORES   = 4;
    localparam int BLOCK_WORDS = 4;
    localparam int ID_W        = 8;
    localparam int FIFO_DEPTH  = 8;

    localparam int BLOCK_BITS  = BLOCK_WORDS * 32;
    localparam int CORE_IDX_W  = $clog2(NUM_CORES);
    localparam int CNT_W       = $clog2(NUM_CORES + 1);

    typedef logic [CORE_IDX_W-1:0] core_idx_t;

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic                  serial;
        logic [BLOCK_BITS-1:0] data;
    } block_t;

    typedef struct packed {
        logic      valid;
        core_idx_t idx;
    } grant_t;

    function automatic core_idx_t core_inc(input core_idx_t p);
        return (p == core_idx_t'(NUM_CORES - 1)) ? '0 : p + 1'b1;
    endfunction

    // First set bit of free_mask at or after ptr, wrapping at NUM_CORES (need not be a power of two).
    function automatic grant_t rr_pick(input logic [NUM_CORES-1:0] free_mask, input core_idx_t ptr);
        grant_t    g;
        int        idx;
        core_idx_t idx_c;
        g = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CORES) idx -= NUM_CORES;
            idx_c = core_idx_t'(idx);
            if (!g.valid && free_mask[idx_c]) begin
                g.valid = 1'b1;
                g.idx   = idx_c;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/ife_multicore_dispatcher_if.sv
// Block-source, core-array and commit signals of the dispatcher bundled as one interface.
// master = block source / core array side, slave = dispatcher.
interface ife_multicore_dispatcher_if;
    import ife_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [ID_W-1:0]       in_id;
    logic [BLOCK_BITS-1:0] in_data;
    logic                  in_serial;
    logic [NUM_CORES-1:0]  core_busy;
    logic [NUM_CORES-1:0]  core_done;
    logic [NUM_CORES-1:0]  disp_valid;
    logic [ID_W-1:0]       disp_id;
    logic [BLOCK_BITS-1:0] disp_data;
    logic                  commit_valid;
    logic [ID_W-1:0]       commit_id;
    core_idx_t             commit_core;
    logic [CNT_W-1:0]      inflight_cnt;
    logic                  err_spurious;

    modport master (
        output in_valid, in_id, in_data, in_serial, core_busy, core_done,
        input  in_ready, disp_valid, disp_id, disp_data, commit_valid, commit_id,
               commit_core, inflight_cnt, err_spurious
    );

    modport slave (
        input  in_valid, in_id, in_data, in_serial, core_busy, core_done,
        output in_ready, disp_valid, disp_id, disp_data, commit_valid, commit_id,
               commit_core, inflight_cnt, err_spurious
    );

endinterface

// File: rtl/ife_block_fifo.sv
// Synchronous in-order queue of instruction blocks with full/empty flags.
// Pushes into a full queue and pops from an empty one are ignored.
module ife_block_fifo
    import ife_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_i,
    input  block_t din_i,
    input  logic   pop_i,
    output block_t dout_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    block_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, wr_q;
    logic [OCC_W-1:0] occ_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (occ_q == OCC_W'(DEPTH));
    assign empty_o = (occ_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q];

    // NOTE: storage has no reset; the pointers and occupancy alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    // NOTE: state uses <= so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            occ_q <= '0;
        end else begin
            if (do_push) wr_q <= ptr_inc(wr_q);
            if (do_pop)  rd_q <= ptr_inc(rd_q);
            occ_q <= occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
        end
    end

endmodule

// File: rtl/ife_multicore_dispatcher.sv
// Queues instruction blocks, dispatches them round-robin over NUM_CORES cores with serial barriers,
// and commits completions strictly in dispatch order.
module ife_multicore_dispatcher
    import ife_pkg::*;
(
    input logic                       clk,
    input logic                       rst_n,
    ife_multicore_dispatcher_if.slave bus
);

    block_t fifo_din, fifo_head;
    logic   fifo_full, fifo_empty, fifo_push, fifo_pop;

    logic [NUM_CORES-1:0] inflight_q, inflight_d;
    logic [NUM_CORES-1:0] done_q, done_d, done_set;
    logic [NUM_CORES-1:0] core_free;
    core_idx_t            rr_ptr_q, rr_ptr_d;
    logic                 serial_busy_q, serial_busy_d;
    logic [CNT_W-1:0]     inflight_cnt;
    grant_t               grant;
    logic                 commit;
    logic                 spurious;

    // Order queue: one entry per in-flight block, oldest at oq_rd_q.
    core_idx_t        oq_core_q [NUM_CORES];
    logic [ID_W-1:0]  oq_id_q   [NUM_CORES];
    core_idx_t        oq_rd_q, oq_wr_q, head_core;
    logic [CNT_W-1:0] oq_cnt_q;

    logic [NUM_CORES-1:0]  disp_valid_q;
    logic [ID_W-1:0]       disp_id_q;
    logic [BLOCK_BITS-1:0] disp_data_q;
    logic                  commit_valid_q;
    logic [ID_W-1:0]       commit_id_q;
    core_idx_t             commit_core_q;
    logic                  err_spurious_q;

    assign fifo_din     = '{id: bus.in_id, serial: bus.in_serial, data: bus.in_data};
    assign bus.in_ready = rst_n && !fifo_full;
    assign fifo_push    = bus.in_valid && bus.in_ready;
    assign fifo_pop     = grant.valid;

    ife_block_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign core_free    = ~bus.core_busy & ~inflight_q;
    assign inflight_cnt = CNT_W'($countones(inflight_q));
    assign head_core    = oq_core_q[oq_rd_q];

    // A serial block needs an empty machine; while it runs, parallel blocks wait behind it.
    always_comb begin
        grant = '0;
        if (!fifo_empty) begin
            if (fifo_head.serial) begin
                if (inflight_cnt == '0 && core_free[0]) grant = '{valid: 1'b1, idx: '0};
            end else if (!serial_busy_q) begin
                grant = rr_pick(core_free, rr_ptr_q);
            end
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        done_set      = done_q | (bus.core_done & inflight_q);
        spurious      = |(bus.core_done & ~inflight_q);
        commit        = (oq_cnt_q != '0) && done_set[head_core];
        inflight_d    = inflight_q;
        done_d        = done_set;
        serial_busy_d = serial_busy_q;
        rr_ptr_d      = rr_ptr_q;
        if (commit) begin
            inflight_d[head_core] = 1'b0;
            done_d[head_core]     = 1'b0;
            serial_busy_d         = 1'b0;
        end
        if (grant.valid) begin
            inflight_d[grant.idx] = 1'b1;
            if (fifo_head.serial) serial_busy_d = 1'b1;
            else                  rr_ptr_d      = core_inc(grant.idx);
        end
    end

    always_ff @(posedge clk) begin
        if (grant.valid) begin
            oq_core_q[oq_wr_q] <= grant.idx;
            oq_id_q[oq_wr_q]   <= fifo_head.id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_q     <= '0;
            done_q         <= '0;
            rr_ptr_q       <= '0;
            serial_busy_q  <= 1'b0;
            oq_rd_q        <= '0;
            oq_wr_q        <= '0;
            oq_cnt_q       <= '0;
            disp_valid_q   <= '0;
            disp_id_q      <= '0;
            disp_data_q    <= '0;
            commit_valid_q <= 1'b0;
            commit_id_q    <= '0;
            commit_core_q  <= '0;
            err_spurious_q <= 1'b0;
        end else begin
            inflight_q     <= inflight_d;
            done_q         <= done_d;
            rr_ptr_q       <= rr_ptr_d;
            serial_busy_q  <= serial_busy_d;
            err_spurious_q <= err_spurious_q | spurious;
            oq_cnt_q       <= oq_cnt_q + CNT_W'(grant.valid) - CNT_W'(commit);
            if (grant.valid) oq_wr_q <= core_inc(oq_wr_q);
            if (commit)      oq_rd_q <= core_inc(oq_rd_q);

            disp_valid_q <= grant.valid ? (NUM_CORES'(1) << grant.idx) : '0;
            if (grant.valid) begin
                disp_id_q   <= fifo_head.id;
                disp_data_q <= fifo_head.data;
            end

            commit_valid_q <= commit;
            if (commit) begin
                commit_id_q   <= oq_id_q[oq_rd_q];
                commit_core_q <= head_core;
            end
        end
    end

    assign bus.disp_valid   = disp_valid_q;
    assign bus.disp_id      = disp_id_q;
    assign bus.disp_data    = disp_data_q;
    assign bus.commit_valid = commit_valid_q;
    assign bus.commit_id    = commit_id_q;
    assign bus.commit_core  = commit_core_q;
    assign bus.inflight_cnt = inflight_cnt;
    assign bus.err_spurious = err_spurious_q;

endmodule

// File: tb/tb_ife_multicore_dispatcher.sv
// Scoreboard bench for ife_multicore_dispatcher: expected dispatches/commits are queued as blocks
// are offered and matched by a monitor as the DUT produces them.
module tb_ife_multicore_dispatcher;
    import ife_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ife_multicore_dispatcher_if bus ();

    ife_multicore_dispatcher dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int              core;
        logic [ID_W-1:0] id;
    } exp_t;

    exp_t exp_disp[$];
    exp_t exp_commit[$];
    int   disp_cycles[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cycle       = 0;

    function automatic logic [BLOCK_BITS-1:0] blk_data(input logic [ID_W-1:0] id);
        logic [BLOCK_BITS-1:0] d;
        for (int w = 0; w < BLOCK_WORDS; w++) d[w*32 +: 32] = {id, 8'(w), 16'hBEEF};
        return d;
    endfunction

    task automatic monitor();
        exp_t                 e;
        logic [NUM_CORES-1:0] want_oh;
        forever begin
            @(negedge clk);
            cycle++;
            if (rst_n === 1'b1 && bus.disp_valid !== '0) begin
                vectors++;
                if (exp_disp.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_dispatch: disp_valid=%b id=%0d, none expected", bus.disp_valid, bus.disp_id);
                end else begin
                    e = exp_disp.pop_front();
                    want_oh = NUM_CORES'(1) << e.core;
                    disp_cycles.push_back(cycle);
                    if (bus.disp_valid !== want_oh || bus.disp_id !== e.id || bus.disp_data !== blk_data(e.id)) begin
                        miscompares++;
                        $display("FAIL dispatch: got valid=%b id=%0d data=%h, want valid=%b id=%0d data=%h",
                                 bus.disp_valid, bus.disp_id, bus.disp_data, want_oh, e.id, blk_data(e.id));
                    end
                end
            end
            if (rst_n === 1'b1 && bus.commit_valid !== 1'b0) begin
                vectors++;
                if (exp_commit.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_commit: commit id=%0d core=%0d, none expected", bus.commit_id, bus.commit_core);
                end else begin
                    e = exp_commit.pop_front();
                    if (bus.commit_id !== e.id || bus.commit_core !== core_idx_t'(e.core)) begin
                        miscompares++;
                        $display("FAIL commit: got id=%0d core=%0d, want id=%0d core=%0d",
                                 bus.commit_id, bus.commit_core, e.id, e.core);
                    end
                end
            end
        end
    endtask

    task automatic send_block(input logic [ID_W-1:0] id, input logic serial, input int exp_core, input bit exp_cmt);
        int b = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && b < 200) begin
            @(negedge clk);
            b++;
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL send_ready id=%0d: in_ready=%b, want 1", id, bus.in_ready);
        end
        bus.in_valid  = 1'b1;
        bus.in_id     = id;
        bus.in_serial = serial;
        bus.in_data   = blk_data(id);
        if (exp_core >= 0) exp_disp.push_back('{core: exp_core, id: id});
        if (exp_cmt)       exp_commit.push_back('{core: exp_core, id: id});
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_disp(input int left, input string what);
        int b = 0;
        while (exp_disp.size() > left && b < 200) begin
            @(negedge clk);
            b++;
        end
        vectors++;
        if (exp_disp.size() > left) begin
            miscompares++;
            $display("FAIL %s: %0d dispatches outstanding, want %0d", what, exp_disp.size(), left);
        end
    endtask

    task automatic wait_commit(input int left, input string what);
        int b = 0;
        while (exp_commit.size() > left && b < 200) begin
            @(negedge clk);
            b++;
        end
        vectors++;
        if (exp_commit.size() > left) begin
            miscompares++;
            $display("FAIL %s: %0d commits outstanding, want %0d", what, exp_commit.size(), left);
        end
    endtask

    task automatic pulse_done(input logic [NUM_CORES-1:0] mask);
        @(negedge clk);
        bus.core_done = mask;
        @(negedge clk);
        bus.core_done = '0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_id     = '0;
        bus.in_data   = '0;
        bus.in_serial = 1'b0;
        bus.core_busy = '0;
        bus.core_done = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b, want 0", bus.in_ready);
        end
        vectors++;
        if ({bus.disp_valid, bus.disp_id, bus.disp_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_disp: valid=%b id=%0d data=%h, want all 0", bus.disp_valid, bus.disp_id, bus.disp_data);
        end
        vectors++;
        if ({bus.commit_valid, bus.commit_id, bus.commit_core, bus.inflight_cnt, bus.err_spurious} !== '0) begin
            miscompares++;
            $display("FAIL reset_commit: valid=%b id=%0d core=%0d cnt=%0d err=%b, want all 0",
                     bus.commit_valid, bus.commit_id, bus.commit_core, bus.inflight_cnt, bus.err_spurious);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_in_ready: got %b, want 1", bus.in_ready);
        end
    endtask

    task automatic test_round_robin();
        disp_cycles.delete();
        for (int i = 1; i <= 4; i++) send_block(ID_W'(i), 1'b0, i - 1, 1'b1);
        wait_disp(0, "rr_four");
        vectors++;
        if (disp_cycles.size() != 4) begin
            miscompares++;
            $display("FAIL rr_count: got %0d dispatches, want 4", disp_cycles.size());
        end
        for (int k = 1; k < disp_cycles.size(); k++) begin
            vectors++;
            if (disp_cycles[k] - disp_cycles[k-1] != 1) begin
                miscompares++;
                $display("FAIL rr_back_to_back: gap %0d cycles before dispatch %0d, want 1", disp_cycles[k] - disp_cycles[k-1], k);
            end
        end
        vectors++;
        if (bus.inflight_cnt !== CNT_W'(4)) begin
            miscompares++;
            $display("FAIL rr_inflight: got %0d, want 4", bus.inflight_cnt);
        end
        pulse_done('1);
        wait_commit(0, "rr_commits");
        @(negedge clk);
        vectors++;
        if (bus.inflight_cnt !== '0) begin
            miscompares++;
            $display("FAIL rr_drained: inflight_cnt=%0d, want 0", bus.inflight_cnt);
        end
        send_block(8'd11, 1'b0, 0, 1'b1);
        wait_disp(0, "rr_wrap");
        pulse_done(4'b0001);
        wait_commit(0, "rr_wrap_commit");
    endtask

    task automatic test_busy_skip();
        bus.core_busy = 4'b0010;
        send_block(8'd12, 1'b0, 2, 1'b1);
        send_block(8'd13, 1'b0, 3, 1'b1);
        wait_disp(0, "busy_skip");
        pulse_done(4'b1100);
        wait_commit(0, "busy_skip_commit");
        bus.core_busy = '0;
    endtask

    task automatic test_commit_order();
        send_block(8'd5, 1'b0, 0, 1'b1);
        send_block(8'd6, 1'b0, 1, 1'b1);
        send_block(8'd7, 1'b0, 2, 1'b1);
        wait_disp(0, "order_dispatch");
        pulse_done(4'b0100);
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_commit.size() != 3) begin
            miscompares++;
            $display("FAIL order_hold_young: %0d commits outstanding, want 3", exp_commit.size());
        end
        pulse_done(4'b0001);
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_commit.size() != 2) begin
            miscompares++;
            $display("FAIL order_wait_core1: %0d commits outstanding, want 2", exp_commit.size());
        end
        pulse_done(4'b0010);
        wait_commit(0, "order_drain");
        vectors++;
        if (bus.err_spurious !== 1'b0) begin
            miscompares++;
            $display("FAIL order_no_spurious: err_spurious=%b, want 0", bus.err_spurious);
        end
    endtask

    task automatic test_serial_barrier();
        send_block(8'd8,  1'b0, 3, 1'b1);
        send_block(8'd9,  1'b1, 0, 1'b1);
        send_block(8'd10, 1'b0, 0, 1'b1);
        repeat (5) @(negedge clk);
        vectors++;
        if (exp_disp.size() != 2) begin
            miscompares++;
            $display("FAIL serial_waits: %0d dispatches outstanding, want 2", exp_disp.size());
        end
        pulse_done(4'b1000);
        wait_disp(1, "serial_go");
        repeat (4) @(negedge clk);
        vectors++;
        if (exp_disp.size() != 1) begin
            miscompares++;
            $display("FAIL serial_blocks_parallel: %0d dispatches outstanding, want 1", exp_disp.size());
        end
        pulse_done(4'b0001);
        wait_disp(0, "after_serial");
        pulse_done(4'b0001);
        wait_commit(0, "serial_drain");
    endtask

    task automatic test_fill_backpressure();
        bus.core_busy = '1;
        send_block(8'd20, 1'b0, 0, 1'b0);
        for (int i = 21; i < 28; i++) send_block(ID_W'(i), 1'b0, -1, 1'b0);
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: in_ready=%b, want 0", bus.in_ready);
        end
        vectors++;
        if (exp_disp.size() != 1) begin
            miscompares++;
            $display("FAIL fill_no_dispatch: %0d dispatches outstanding, want 1", exp_disp.size());
        end
        bus.core_busy = 4'b1110;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_release: in_ready=%b, want 1", bus.in_ready);
        end
        wait_disp(0, "fill_dispatch");
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.inflight_cnt !== CNT_W'(1)) begin
            miscompares++;
            $display("FAIL fill_single: inflight_cnt=%0d, want 1", bus.inflight_cnt);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.core_busy = '0;
    endtask

    task automatic test_spurious_and_reset();
        vectors++;
        if (bus.err_spurious !== 1'b0) begin
            miscompares++;
            $display("FAIL spur_clear: err_spurious=%b, want 0", bus.err_spurious);
        end
        pulse_done(4'b1000);
        vectors++;
        if (bus.err_spurious !== 1'b1) begin
            miscompares++;
            $display("FAIL spur_set: err_spurious=%b, want 1", bus.err_spurious);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.err_spurious !== 1'b1) begin
            miscompares++;
            $display("FAIL spur_sticky: err_spurious=%b, want 1", bus.err_spurious);
        end
        bus.core_busy = 4'b1110;
        send_block(8'd30, 1'b0, 0, 1'b0);
        wait_disp(0, "pre_reset_dispatch");
        bus.core_busy = '1;
        for (int i = 31; i < 34; i++) send_block(ID_W'(i), 1'b0, -1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_in_ready: got %b, want 0", bus.in_ready);
        end
        @(negedge clk);
        vectors++;
        if ({bus.disp_valid, bus.disp_id, bus.disp_data, bus.commit_valid, bus.commit_id, bus.commit_core,
             bus.inflight_cnt, bus.err_spurious} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: disp=%b id=%0d commit=%b cid=%0d core=%0d cnt=%0d err=%b, want all 0",
                     bus.disp_valid, bus.disp_id, bus.commit_valid, bus.commit_id, bus.commit_core,
                     bus.inflight_cnt, bus.err_spurious);
        end
        rst_n = 1'b1;
        bus.core_busy = '0;
        repeat (10) @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.inflight_cnt !== '0) begin
            miscompares++;
            $display("FAIL post_midreset: in_ready=%b cnt=%0d, want 1 and 0", bus.in_ready, bus.inflight_cnt);
        end
        vectors++;
        if (exp_disp.size() != 0 || exp_commit.size() != 0) begin
            miscompares++;
            $display("FAIL post_midreset_queues: %0d dispatches %0d commits outstanding, want 0",
                     exp_disp.size(), exp_commit.size());
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_round_robin();
        test_busy_skip();
        test_commit_order();
        test_serial_barrier();
        test_fill_backpressure();
        test_spurious_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
